// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared pipeline types and constants for hazard control
package hazard_controller_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [4:0]  REG_X0    = 5'd0;

    // A load in X feeds a source the instruction in D really reads; x0 never creates a dependency
    function automatic logic is_load_use(
        input logic       x_is_load,
        input logic       x_reg_write,
        input logic [4:0] x_rd,
        input logic       d_uses_rs1,
        input logic [4:0] d_rs1,
        input logic       d_uses_rs2,
        input logic [4:0] d_rs2
    );
        return x_is_load && x_reg_write && (x_rd != REG_X0) &&
               ((d_uses_rs1 && (d_rs1 == x_rd)) || (d_uses_rs2 && (d_rs2 == x_rd)));
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// rtl/hazard_controller_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on i_inc, stick at all-ones, clear has priority over increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       i_d_rs1,
    input  logic [4:0]       i_d_rs2,
    input  logic             i_d_uses_rs1,
    input  logic             i_d_uses_rs2,
    input  logic [4:0]       i_x_rd,
    input  logic             i_x_reg_write,
    input  logic             i_x_is_load,
    input  logic             i_x_redirect,
    input  logic             i_m_mem_req,
    input  logic             i_m_mem_ready,
    output logic             o_pc_hold,
    output logic             o_fd_hold,
    output logic             o_fd_flush,
    output logic             o_dx_bubble,
    output logic             o_dx_flush,
    output logic             o_freeze,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count,
    output logic             o_mem_timeout_err
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t          r_state;
    hz_state_t          w_state_next;
    logic               r_mem_timeout_err;
    logic               w_load_use;
    logic               w_mem_stall;
    logic               w_wait_inc;
    logic               w_wait_clr;
    logic [WAIT_W-1:0]  w_wait_cnt;

    assign w_load_use  = is_load_use(i_x_is_load, i_x_reg_write, i_x_rd,
                                     i_d_uses_rs1, i_d_rs1, i_d_uses_rs2, i_d_rs2);
    assign w_mem_stall = i_m_mem_req && !i_m_mem_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: enter the wait on an unfinished access, leave on completion or cancel
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (w_mem_stall) w_state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!w_mem_stall) w_state_next = ST_RUN;
            default:     w_state_next = ST_RUN;
        endcase
    end

    // Control outputs: memory wait beats redirect beats load-use; all quiet while in reset
    always_comb begin
        o_pc_hold   = 1'b0;
        o_fd_hold   = 1'b0;
        o_fd_flush  = 1'b0;
        o_dx_bubble = 1'b0;
        o_dx_flush  = 1'b0;
        o_freeze    = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        o_freeze  = 1'b1;
                        o_pc_hold = 1'b1;
                        o_fd_hold = 1'b1;
                    end else if (i_x_redirect) begin
                        // D holds a wrong-path instruction, so its load-use is irrelevant
                        o_fd_flush = 1'b1;
                        o_dx_flush = 1'b1;
                    end else if (w_load_use) begin
                        o_pc_hold   = 1'b1;
                        o_fd_hold   = 1'b1;
                        o_dx_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    o_freeze  = 1'b1;
                    o_pc_hold = 1'b1;
                    o_fd_hold = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // wait_cnt is zero in RUN; it counts completed wait cycles of the current access
    assign w_wait_inc = ((r_state == ST_RUN) && w_mem_stall) ||
                        ((r_state == ST_MEM_WAIT) && w_mem_stall);
    assign w_wait_clr = (r_state == ST_MEM_WAIT) && !w_mem_stall;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (o_pc_hold),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (1'b0),
        .i_inc   (o_fd_flush),
        .o_count (o_flush_count)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_wait_clr),
        .i_inc   (w_wait_inc),
        .o_count (w_wait_cnt)
    );

    // Sticky timeout flag: sets on the edge that completes the MEM_TIMEOUT-th wait cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_timeout_err <= 1'b0;
        end else if (w_wait_inc && (w_wait_cnt == TIMEOUT_M1)) begin
            r_mem_timeout_err <= 1'b1;
        end
    end

    assign o_mem_timeout_err = r_mem_timeout_err;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  d_rs1, d_rs2, x_rd;
    logic        d_uses_rs1, d_uses_rs2, x_reg_write, x_is_load, x_redirect;
    logic        m_mem_req, m_mem_ready;
    logic        pc_hold, fd_hold, fd_flush, dx_bubble, dx_flush, freeze;
    logic [31:0] stall_cycles, flush_count;
    logic        mem_timeout_err;

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] st;
        logic [31:0] fl;
        logic        err;
    } exp_t;

    // ctl bit order: pc_hold, fd_hold, fd_flush, dx_bubble, dx_flush, freeze
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_FL   = 6'b001010;
    localparam logic [5:0] C_FRZ  = 6'b110001;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_controller #(.CNT_W(32), .MEM_TIMEOUT(64)) dut (
        .clock             (clock),
        .reset             (reset),
        .i_d_rs1           (d_rs1),
        .i_d_rs2           (d_rs2),
        .i_d_uses_rs1      (d_uses_rs1),
        .i_d_uses_rs2      (d_uses_rs2),
        .i_x_rd            (x_rd),
        .i_x_reg_write     (x_reg_write),
        .i_x_is_load       (x_is_load),
        .i_x_redirect      (x_redirect),
        .i_m_mem_req       (m_mem_req),
        .i_m_mem_ready     (m_mem_ready),
        .o_pc_hold         (pc_hold),
        .o_fd_hold         (fd_hold),
        .o_fd_flush        (fd_flush),
        .o_dx_bubble       (dx_bubble),
        .o_dx_flush        (dx_flush),
        .o_freeze          (freeze),
        .o_stall_cycles    (stall_cycles),
        .o_flush_count     (flush_count),
        .o_mem_timeout_err (mem_timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: the DUT presents a full set of outputs every cycle; compare mid-cycle
    always @(negedge clock) begin
        exp_t e;
        logic [5:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_hold, fd_hold, fd_flush, dx_bubble, dx_flush, freeze};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl @%0t: got %b want %b", $time, act, e.ctl);
            end
            checks++;
            if (stall_cycles !== e.st) begin
                errors++;
                $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, e.st);
            end
            checks++;
            if (flush_count !== e.fl) begin
                errors++;
                $display("FAIL flush_count @%0t: got %0d want %0d", $time, flush_count, e.fl);
            end
            checks++;
            if (mem_timeout_err !== e.err) begin
                errors++;
                $display("FAIL mem_timeout_err @%0t: got %b want %b", $time, mem_timeout_err, e.err);
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge, with its expected response
    task automatic cyc(
        input logic rst, input logic xl, input logic xw, input logic [4:0] xrd,
        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
        input logic rdr, input logic req, input logic rdy,
        input logic [5:0] ectl, input int est, input int efl, input logic eerr
    );
        exp_t e;
        @(posedge clock);
        #1;
        reset       = rst;
        x_is_load   = xl;
        x_reg_write = xw;
        x_rd        = xrd;
        d_rs1       = r1;
        d_uses_rs1  = u1;
        d_rs2       = r2;
        d_uses_rs2  = u2;
        x_redirect  = rdr;
        m_mem_req   = req;
        m_mem_ready = rdy;
        e.ctl = ectl;
        e.st  = est;
        e.fl  = efl;
        e.err = eerr;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        {d_rs1, d_rs2, x_rd} = '0;
        {d_uses_rs1, d_uses_rs2, x_reg_write, x_is_load, x_redirect, m_mem_req, m_mem_ready} = '0;

        //  rst xl xw xrd  r1 u1 r2 u2 rdr req rdy  ctl    st  fl err
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        // lw x5 in X, add x6,x5,x1 in D
        cyc(0, 1, 1, 5'd5, 5'd5, 1, 5'd1, 1, 0, 0, 0, C_LU,   0, 0, 0);
        cyc(0, 0, 1, 5'd6, 5'd2, 1, 5'd3, 1, 0, 0, 0, C_NONE, 1, 0, 0);
        // load to x0, D reads x0
        cyc(0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, C_NONE, 1, 0, 0);
        // add (not load) writing x5, D reads x5
        cyc(0, 0, 1, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 0, C_NONE, 1, 0, 0);
        // hazard only through rs2
        cyc(0, 1, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 0, C_LU,   1, 0, 0);
        // register matches but D does not read it
        cyc(0, 1, 1, 5'd9, 5'd9, 0, 5'd4, 1, 0, 0, 0, C_NONE, 2, 0, 0);
        // redirect wins over load-use
        cyc(0, 1, 1, 5'd5, 5'd5, 1, 5'd1, 1, 1, 0, 0, C_FL,   2, 0, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 2, 1, 0);
        // memory ready after 3 cycles, redirect pending in X during the wait
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  2, 1, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, C_FRZ,  3, 1, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, C_FRZ,  4, 1, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_FL,   5, 1, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 5, 2, 0);
        // access that completes in the same cycle does not stall
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, C_NONE, 5, 2, 0);
        // cancelled access
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  5, 2, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_FRZ,  6, 2, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 7, 2, 0);
        // 64 wait cycles: error rises on the edge completing the 64th
        for (int i = 0; i < 64; i++) begin
            cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 7 + i, 2, 0);
        end
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, C_FRZ,  71, 2, 1);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 72, 2, 1);
        // reset asserted in the middle of a memory wait
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  72, 2, 1);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  73, 2, 1);
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_NONE, 0, 0, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, 0, 0);
        // back in RUN: load-use handled normally
        cyc(0, 1, 1, 5'd8, 5'd1, 1, 5'd8, 1, 0, 0, 0, C_LU,   0, 0, 0);
        cyc(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 1, 0, 0);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
